// File: rtl/demux_stream_reg.sv
// Registered 1-to-NCH stream demux: one holding register per channel, 1-cycle latency, per-channel backpressure.
// Define DEMUX_CNT_EN to add per-channel pop counters on out_cnt.
module demux_stream_reg #(
  parameter  int NCH = 4,
  parameter  int DW  = 1,
  parameter  int CW  = 8,
  localparam int SW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SW-1:0]     in_sel,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic              sel_err
`ifdef DEMUX_CNT_EN
  ,
  output logic [NCH*CW-1:0] out_cnt
`endif
);

  if (NCH < 2 || DW < 1 || CW < 1) begin : g_bad_param
    $error("demux_stream_reg: NCH must be >= 2, DW and CW >= 1");
  end

  logic [NCH-1:0]    vld_q, vld_d;
  logic [NCH*DW-1:0] dat_q, dat_d;
  logic              err_q, err_d;
  logic              sel_ok;
  logic              push;
  logic [NCH-1:0]    pop;

  // Widen by one bit so the compare is exact when NCH is a power of two.
  assign sel_ok = ({1'b0, in_sel} < (SW+1)'(NCH));

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (!sel_ok) begin
        in_ready = 1'b1;
      end else begin
        in_ready = ~vld_q[in_sel] | out_ready[in_sel];
      end
    end
  end

  assign push = in_valid & in_ready;
  assign pop  = vld_q & out_ready;

  always_comb begin
    vld_d = vld_q & ~pop;
    dat_d = dat_q;
    err_d = 1'b0;
    if (push) begin
      if (sel_ok) begin
        vld_d[in_sel]             = 1'b1;
        dat_d[in_sel*DW +: DW]    = in_data;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      err_q <= err_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = dat_q;
  assign sel_err   = err_q;

`ifdef DEMUX_CNT_EN
  logic [NCH*CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NCH; k++) begin
      if (pop[k]) begin
        cnt_d[k*CW +: CW] = cnt_q[k*CW +: CW] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`endif

endmodule
